// File: rtl/scratchpad_copy_master.sv
// Avalon-MM block copy/fill engine for a single-port scratchpad with a fixed 1-cycle read latency.
// Define CHECKSUM_EN to add a running modulo-2^DATA_W sum of every written word on port checksum.
module scratchpad_copy_master #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 13
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_fill,
  input  logic [ADDR_W-1:0]   cmd_src,
  input  logic [ADDR_W-1:0]   cmd_dst,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic [DATA_W-1:0]   cmd_pattern,
  input  logic                hold,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   sp_address,
  output logic [DATA_W/8-1:0] sp_byteenable,
  output logic                sp_chipselect,
  output logic                sp_write,
  output logic [DATA_W-1:0]   sp_writedata,
  output logic                sp_clken,
  input  logic [DATA_W-1:0]   sp_readdata
`ifdef CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]   checksum
`endif
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2**ADDR_W);

  typedef enum logic [2:0] {IDLE, RD, LAT, WR, FIN} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   src_ptr, dst_ptr;
  logic [LEN_W-1:0]    remaining;
  logic                fill_q;
  logic [DATA_W-1:0]   pattern_q, data_q;
  logic                accept;

  // Lengths beyond the scratchpad depth would only rewrite the same words again.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    if (len > MAX_LEN) return MAX_LEN;
    return len;
  endfunction

  always_comb begin
    state_nxt     = state;
    accept        = 1'b0;
    cmd_ready     = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    sp_chipselect = 1'b0;
    sp_write      = 1'b0;
    sp_address    = '0;
    sp_writedata  = '0;
    case (state)
      IDLE: begin
        busy      = 1'b0;
        cmd_ready = ~hold;
        if (cmd_valid && !hold) begin
          accept = 1'b1;
          if (clamp_len(cmd_len) == '0) state_nxt = FIN;
          else if (cmd_fill)            state_nxt = WR;
          else                          state_nxt = RD;
        end
      end
      RD: begin
        sp_chipselect = ~reset;
        sp_address    = src_ptr;
        state_nxt     = LAT;
      end
      LAT: state_nxt = WR;
      WR: begin
        sp_chipselect = ~reset;
        sp_write      = ~reset;
        sp_address    = dst_ptr;
        sp_writedata  = fill_q ? pattern_q : data_q;
        if (remaining == LEN_W'(1)) state_nxt = FIN;
        else if (fill_q)            state_nxt = WR;
        else                        state_nxt = RD;
      end
      FIN: begin
        done      = ~hold & ~reset;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign sp_byteenable = {(DATA_W/8){sp_chipselect}};
  assign sp_clken      = ~hold;

  // Control path: the whole engine freezes while hold is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
      fill_q    <= 1'b0;
    end else if (!hold) begin
      state <= state_nxt;
      if (accept) begin
        src_ptr   <= cmd_src;
        dst_ptr   <= cmd_dst;
        remaining <= clamp_len(cmd_len);
        fill_q    <= cmd_fill;
      end else if (state == WR) begin
        src_ptr   <= src_ptr + ADDR_W'(1);
        dst_ptr   <= dst_ptr + ADDR_W'(1);
        remaining <= remaining - LEN_W'(1);
      end
    end
  end

  // Data path: read data lands at the end of LAT, one cycle after the RD address.
  always_ff @(posedge clk) begin
    if (!hold) begin
      if (accept)       pattern_q <= cmd_pattern;
      if (state == LAT) data_q    <= sp_readdata;
    end
  end

`ifdef CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      checksum <= '0;
    end else if (!hold) begin
      if (accept)                        checksum <= '0;
      else if (state == WR)              checksum <= checksum + sp_writedata;
    end
  end
`endif

endmodule

// File: tb/tb_scratchpad_copy_master.sv
// Bench for scratchpad_copy_master: scratchpad slave model, word-level reference model of copy/fill,
// and a per-cycle compare of strobes, latencies and handshakes against it.
module tb_scratchpad_copy_master;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 13;
  localparam int DEPTH  = 4096;

  logic              clk = 1'b0;
  logic              reset, cmd_valid, cmd_fill, hold;
  logic [ADDR_W-1:0] cmd_src, cmd_dst;
  logic [LEN_W-1:0]  cmd_len;
  logic [DATA_W-1:0] cmd_pattern;
  logic              cmd_ready, busy, done;
  logic [ADDR_W-1:0] sp_address;
  logic [3:0]        sp_byteenable;
  logic              sp_chipselect, sp_write, sp_clken;
  logic [DATA_W-1:0] sp_writedata, sp_readdata;
`ifdef CHECKSUM_EN
  logic [DATA_W-1:0] checksum;
`endif

  scratchpad_copy_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_fill(cmd_fill), .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
    .cmd_pattern(cmd_pattern), .hold(hold), .busy(busy), .done(done),
    .sp_address(sp_address), .sp_byteenable(sp_byteenable), .sp_chipselect(sp_chipselect),
    .sp_write(sp_write), .sp_writedata(sp_writedata), .sp_clken(sp_clken),
    .sp_readdata(sp_readdata)
`ifdef CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // Scratchpad slave: 1-cycle registered read, everything frozen when clken is low.
  logic [31:0]       mem [DEPTH];
  logic              init_en, pl_en;
  logic [ADDR_W-1:0] pl_addr;
  logic [31:0]       pl_data;
  always @(posedge clk) begin
    if (init_en) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
    end else if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (sp_clken && sp_chipselect) begin
      if (sp_write) mem[sp_address] <= sp_writedata;
      else          sp_readdata     <= mem[sp_address];
    end
  end

  logic [31:0] refm [DEPTH];
  logic [31:0] tmp  [DEPTH];
  logic [31:0] exp_d [DEPTH];
  int          exp_a [DEPTH];
  logic [31:0] exp_sum;
  int exp_n, exp_base;
  int checks = 0, failures = 0;
  int cyc = 0, acc_cyc = 0, done_cyc = 0, holds = 0, wr_idx = 0, cs_cnt = 0, clk_low = 0;
  bit in_op = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic check();
    if (reset) begin
      in_op = 1'b0;
      return;
    end
    chk("clken", sp_clken, !hold);
    chk("byteenable", sp_byteenable, sp_chipselect ? 4'hF : 4'h0);
    chk("busy", busy, in_op);
    chk("cmd_ready", cmd_ready, !in_op && !hold);
    if (in_op) begin
      if (hold)           holds++;
      if (sp_chipselect)  cs_cnt++;
      if (!sp_clken)      clk_low++;
    end
    if (sp_chipselect && sp_write && sp_clken) begin
      if (!in_op)                chk("write_while_idle", sp_write, 0);
      else if (wr_idx >= exp_n)  chk("write_overrun", wr_idx, exp_n - 1);
      else begin
        chk("write_addr", sp_address, exp_a[wr_idx]);
        chk("write_data", sp_writedata, exp_d[wr_idx]);
        wr_idx++;
      end
    end
    if (done) begin
      if (!in_op) chk("done_while_idle", done, 0);
      else begin
        chk("done_cycle", cyc, acc_cyc + exp_base + holds);
        chk("write_total", wr_idx, exp_n);
`ifdef CHECKSUM_EN
        chk("checksum_done", checksum, exp_sum);
`endif
        done_cyc = cyc;
        in_op    = 1'b0;
      end
    end
    if (cmd_valid && cmd_ready) begin
      in_op = 1'b1; acc_cyc = cyc; holds = 0; wr_idx = 0; cs_cnt = 0; clk_low = 0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic poke(input int a, input logic [31:0] v);
    pl_en = 1'b1; pl_addr = ADDR_W'(a); pl_data = v;
    step();
    pl_en = 1'b0;
    refm[a] = v;
  endtask

  task automatic mem_compare(input string nm);
    int bad = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== refm[i]) bad++;
    chk(nm, bad, 0);
  endtask

  // Word-by-word ascending reference of the whole operation, then drive and follow the command.
  task automatic run_cmd(input logic f, input int s, input int d, input int l, input logic [31:0] p,
                         input int hold_pct, input int hs, input int hl, input int rst_k,
                         output int lat);
    int n, budget;
    bit acc;
    n = (l > DEPTH) ? DEPTH : l;
    tmp = refm;
    exp_sum = '0;
    for (int i = 0; i < n; i++) begin
      exp_a[i] = (d + i) % DEPTH;
      exp_d[i] = f ? p : tmp[(s + i) % DEPTH];
      tmp[exp_a[i]] = exp_d[i];
      exp_sum += exp_d[i];
    end
    exp_n    = n;
    exp_base = (n == 0) ? 1 : (f ? n + 1 : 3 * n + 1);
    cmd_fill = f; cmd_src = ADDR_W'(s); cmd_dst = ADDR_W'(d);
    cmd_len = LEN_W'(l); cmd_pattern = p; cmd_valid = 1'b1;
    acc = 1'b0;
    lat = -1;
    for (int t = 0; t < 50 && !acc; t++) begin
      hold = (int'($urandom_range(99)) < hold_pct);
      step();
      if (in_op) acc = 1'b1;
    end
    cmd_valid = 1'b0;
    if (!acc) begin
      chk("accept_timeout", cmd_ready, 1);
      hold = 1'b0;
      return;
    end
    budget = 6 * n + 200 + hl;
    for (int t = 0; t < budget && in_op; t++) begin
      int k;
      k = cyc - acc_cyc;
      if (k == rst_k) begin
        reset = 1'b1; hold = 1'b0;
        step();
        reset = 1'b0;
        break;
      end
      hold = (k >= hs && k < hs + hl) || (int'($urandom_range(99)) < hold_pct);
      step();
    end
    hold = 1'b0;
    if (rst_k < 0) begin
      if (in_op) begin
        chk("done_timeout", done, 1);
        in_op = 1'b0;
      end else begin
        lat  = done_cyc - acc_cyc;
        refm = tmp;
      end
    end
  endtask

  initial begin
    int lat;
    logic [31:0] o500, o501;
    reset = 1'b1; cmd_valid = 1'b0; cmd_fill = 1'b0; hold = 1'b0;
    cmd_src = '0; cmd_dst = '0; cmd_len = '0; cmd_pattern = '0;
    init_en = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    step();
    init_en = 1'b0;
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) refm[i] = init_word(i);

    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sp_address", sp_address, 0);
    chk("rst_sp_byteenable", sp_byteenable, 0);
    chk("rst_sp_chipselect", sp_chipselect, 0);
    chk("rst_sp_write", sp_write, 0);
    chk("rst_sp_writedata", sp_writedata, 0);

    // Basic copy of 1,2,3,4 to 100..103.
    for (int i = 0; i < 4; i++) poke(i, 32'(i + 1));
    run_cmd(1'b0, 0, 100, 4, 32'h0, 0, 0, 0, -1, lat);
    for (int i = 0; i < 4; i++) chk("model_copy", refm[100 + i], 32'(i + 1));
    for (int i = 0; i < 4; i++) chk("mem_copy", mem[100 + i], 32'(i + 1));
    chk("copy4_latency", lat, 13);
    chk("copy4_writes", wr_idx, 4);
    chk("copy4_selects", cs_cnt, 8);
    mem_compare("mem_after_copy4");

    // Fill across the top-of-memory wrap.
    run_cmd(1'b1, 0, 4094, 4, 32'hDEADBEEF, 0, 0, 0, -1, lat);
    chk("fill_wrap_latency", lat, 5);
    chk("fill_4094", mem[4094], 32'hDEADBEEF);
    chk("fill_4095", mem[4095], 32'hDEADBEEF);
    chk("fill_0", mem[0], 32'hDEADBEEF);
    chk("fill_1", mem[1], 32'hDEADBEEF);
    chk("fill_2_untouched", mem[2], 32'd3);

    // Zero length.
    run_cmd(1'b0, 10, 20, 0, 32'h0, 0, 0, 0, -1, lat);
    chk("len0_latency", lat, 1);
    chk("len0_selects", cs_cnt, 0);
    chk("len0_ready_after", cmd_ready, 1);

    // Copy with a 5-cycle hold over the LAT state.
    poke(600, 32'hA5A5_0001);
    poke(601, 32'h5A5A_0002);
    run_cmd(1'b0, 600, 700, 2, 32'h0, 0, 2, 5, -1, lat);
    chk("hold_latency", lat, 12);
    chk("hold_clken_low", clk_low, 5);
    chk("hold_word0", mem[700], 32'hA5A5_0001);
    chk("hold_word1", mem[701], 32'h5A5A_0002);

    // Overlapping copy with dst above src replicates the first two words.
    o500 = refm[500];
    o501 = refm[501];
    run_cmd(1'b0, 500, 502, 6, 32'h0, 0, 0, 0, -1, lat);
    chk("overlap_504", mem[504], o500);
    chk("overlap_507", mem[507], o501);
    mem_compare("mem_after_overlap");

    // Checksum wraps modulo 2^32.
    poke(300, 32'hFFFF_FFFF);
    poke(301, 32'h0000_0002);
    run_cmd(1'b0, 300, 310, 2, 32'h0, 0, 0, 0, -1, lat);
    chk("sum_copy_latency", lat, 7);
`ifdef CHECKSUM_EN
    chk("checksum_wrap", checksum, 32'h0000_0001);
`endif

    // Reset during the second WR cycle of a fill.
    run_cmd(1'b1, 0, 200, 8, 32'hC0FF_EE00, 0, 0, 0, 2, lat);
    chk("rstop_cmd_ready", cmd_ready, 1);
    chk("rstop_busy", busy, 0);
    chk("rstop_sp_chipselect", sp_chipselect, 0);
    chk("rstop_sp_write", sp_write, 0);
    chk("rstop_sp_address", sp_address, 0);
    chk("rstop_sp_writedata", sp_writedata, 0);
    chk("rstop_sp_byteenable", sp_byteenable, 0);
    for (int i = 0; i < 4; i++) step();
    chk("rstop_writes", wr_idx, 1);
    refm[200] = 32'hC0FF_EE00;
    chk("rstop_word0", mem[200], 32'hC0FF_EE00);
    mem_compare("mem_after_reset");

    // Oversized length is clamped to the full depth.
    run_cmd(1'b1, 0, 17, 5000, 32'h1357_9BDF, 0, 0, 0, -1, lat);
    chk("clamp_latency", lat, 4097);
    chk("clamp_writes", wr_idx, 4096);
    mem_compare("mem_after_clamp");

    // Randomized commands with random stalls.
    for (int r = 0; r < 30; r++) begin
      int s, d, l;
      logic f;
      f = 1'($urandom_range(1));
      s = int'($urandom_range(4095));
      d = ($urandom_range(3) == 0) ? 4080 + int'($urandom_range(15)) : int'($urandom_range(4095));
      l = int'($urandom_range(24));
      run_cmd(f, s, d, l, $urandom, 20, 0, 0, -1, lat);
      mem_compare("mem_random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scratchpad_copy_master.md
Name: scratchpad_copy_master

Overview:
Avalon-MM initiator that drives the single-port, 4096x32 processor scratchpad slave port. It performs block copy or block fill operations inside the scratchpad on command. Sits beside each processor's scratchpad so fingerprint and checkpoint data can be moved or cleared without CPU load cycles. Fixed slave read latency of 1 cycle is built into the FSM.

Parameters:
ADDR_W, 12, scratchpad word-address width (depth 2^ADDR_W)
DATA_W, 32, data width; byteenable width is DATA_W/8
LEN_W, 13, command length width; maximum meaningful length is 2^ADDR_W words

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid & cmd_ready
cmd_fill  in  1  1 = fill dst with cmd_pattern; 0 = copy src to dst
cmd_src  in  ADDR_W  source word address (ignored for fill)
cmd_dst  in  ADDR_W  destination word address
cmd_len  in  LEN_W  word count
cmd_pattern  in  DATA_W  fill value
hold  in  1  stall request; freezes the engine
busy  out  1  high from acceptance until done
done  out  1  one-cycle pulse when the operation completes
sp_address  out  ADDR_W  to slave address
sp_byteenable  out  DATA_W/8  always all ones while chipselect is high, else 0
sp_chipselect  out  1  slave select
sp_write  out  1  slave write
sp_writedata  out  DATA_W  slave write data
sp_clken  out  1  slave clock enable; equals ~hold
sp_readdata  in  DATA_W  slave read data, valid 1 cycle after the read address is presented

Behaviour:
- Reset values: cmd_ready=1, busy=0, done=0, sp_address=0, sp_byteenable=0, sp_chipselect=0, sp_write=0, sp_writedata=0. Internal counters are cleared and the state is IDLE.
- States: IDLE, RD, LAT, WR, FIN.
- IDLE: on accept, latch src/dst/pattern/fill. Latch len as min(cmd_len, 2^ADDR_W).
  - len==0 goes to FIN.
  - fill goes to WR.
  - copy goes to RD.
- RD (copy only): chipselect=1, write=0, address=src_ptr. Next state LAT.
- LAT: chipselect=0. Capture sp_readdata into data_reg at the end of the cycle. Next state WR.
- WR: chipselect=1, write=1, address=dst_ptr, writedata = fill ? pattern : data_reg.
  - Then increment both pointers modulo 2^ADDR_W (wrap 4095->0) and decrement remaining.
  - If remaining becomes 0, go to FIN; else go to RD (copy) or stay in WR (fill).
- FIN: done=1 for exactly one cycle, busy=0 on the next cycle, return to IDLE.
- Throughput: copy is 3 cycles/word; fill is 1 cycle/word. A len=N copy asserts done 3N+1 cycles after acceptance; a fill asserts done N+1 cycles after acceptance.
- Copy order is always ascending. Overlapping regions with dst>src propagate already-written words; this is defined behaviour, not an error.
- hold=1:
  - FSM, pointers, counters and all sp_* outputs are frozen.
  - sp_clken=0, so the slave also freezes and readdata timing is preserved.
  - done is not asserted until the cycle in which FIN executes with hold=0.
- cmd_valid while busy is ignored; cmd_ready=0.
- Reset mid-operation: returns to IDLE on the next edge. No done pulse. Words already written stay written.

Optional Feature:
CHECKSUM_EN:
- When defined, adds output checksum[DATA_W-1:0]. It is cleared on reset and on command accept.
- Every word written in WR is added modulo 2^DATA_W.
- The value is stable from the done pulse until the next accept.
- When not defined, there is no checksum port and no adder.

Test Plan:
- Preload scratch[0..3]=1,2,3,4; copy src=0 dst=100 len=4 -> scratch[100..103]=1,2,3,4; done exactly 13 cycles after accept; exactly 4 write strobes.
- Fill dst=4094 len=4 pattern=0xDEADBEEF -> words 4094,4095,0,1 written; done 5 cycles after accept.
- len=0 -> no chipselect asserted; done 1 cycle after accept; cmd_ready back high the following cycle.
- Copy len=2, hold high for 5 cycles during LAT -> sp_clken=0 for those 5 cycles; correct data written; done delayed by exactly 5 cycles (12 total).
- Reset asserted in the 2nd WR of a len=8 fill -> only the 1st word changed; no done pulse; cmd_ready=1 and all sp_* outputs 0 the cycle after reset.
- With CHECKSUM_EN: copy values 0xFFFFFFFF, 2 -> checksum=0x00000001 at done; cmd_len=5000 is clamped to 4096 words.
